// File: rtl/multiword_add_pkg.sv
// rtl/multiword_add_pkg.sv - shared FSM state type and sizing helper for the multiword adder
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk index width; a single-chunk operand still needs one bit.
  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_chunk_adder.sv
// rtl/multiword_add_sequencer_chunk_adder.sv - N-bit adder slice with carry-in and carry-out
module chunk_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};

endmodule

// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - W=N*K bit adder that reuses one N-bit slice over K cycles
// Optional subtract mode (sub port) is enabled by defining MULTIWORD_ADD_SUB_EN.
module multiword_add_sequencer
  import multiword_add_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic         cin,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N*K-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int W  = N * K;
  localparam int IW = idx_width(K);
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic [N-1:0]  slice_sum;
  logic          slice_cout;
  logic [W-1:0]  b_eff;
  logic          c_init;

`ifdef MULTIWORD_ADD_SUB_EN
  // Subtract as a + ~b + 1; final carry set means no borrow.
  assign b_eff  = sub ? ~b : b;
  assign c_init = sub ? 1'b1 : cin;
`else
  assign b_eff  = b;
  assign c_init = cin;
`endif

  chunk_adder #(.N(N)) u_slice (
    .x  (a_q[int'(idx)*N +: N]),
    .y  (b_q[int'(idx)*N +: N]),
    .ci (carry),
    .s  (slice_sum),
    .co (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b_eff;
            carry      <= c_init;
            idx        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_q[int'(idx)*N +: N] <= slice_sum;
          carry                   <= slice_cout;
          // idx parks at K-1 rather than wrapping once the last chunk is done.
          if (idx == LAST) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = carry;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - directed self-checking bench for multiword_add_sequencer (N=4, K=4)
module tb_multiword_add_sequencer;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef MULTIWORD_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int fails  = 0;

  multiword_add_sequencer #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef MULTIWORD_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request while in IDLE; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(K));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_ovalid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_iready_after"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W-1:0] esum, input logic ecout);
    int lat;
    issue(av, bv, cv);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_iready_run"}, 32'(in_ready), 32'd0);
    wait_done(tag, lat);
    check({tag, "_sum"}, 32'(sum), 32'(esum));
    check({tag, "_cout"}, 32'(cout), 32'(ecout));
    consume(tag);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    // Request presented with reset release: must be taken on the first edge.
    rst_n = 1'b1;
    run_op("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("no_carry", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_op("cin_in", 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0);
    run_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    // Backpressure: result held while out_ready is low; new requests ignored.
    issue(16'h0F0F, 16'h0101, 1'b0);
    wait_done("stall", lat);
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_sum", 32'(sum), 32'h1010);
      check("stall_cout", 32'(cout), 32'd0);
      check("stall_ovalid", 32'(out_valid), 32'd1);
      check("stall_iready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume("stall");

    // Reset asserted mid-RUN with idx=2 discards the operation.
    issue(16'h1234, 16'h4321, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_ovalid", 32'(out_valid), 32'd0);
    check("midrst_iready", 32'(in_ready), 32'd1);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    check("midrst_idle_iready", 32'(in_ready), 32'd1);

    run_op("post_rst", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

`ifdef MULTIWORD_ADD_SUB_EN
    sub = 1'b1;
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
    sub = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: chunk width in bits, the width of the single shared adder slice; N >= 1.
REQ-002 SHALL have parameter K, default 4: chunks per operand; operand width W = N*K; K >= 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: request valid.
REQ-006 SHALL have port in_ready, output, 1 bit: request accepted at a rising edge when in_valid && in_ready.
REQ-007 SHALL have ports a and b, inputs, W bits each: operands.
REQ-008 SHALL have port cin, input, 1 bit: operation carry-in.
REQ-009 SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 SHALL have port out_ready, input, 1 bit: result consumed at a rising edge when out_valid && out_ready.
REQ-011 SHALL have port sum, output, W bits: result.
REQ-012 SHALL have port cout, output, 1 bit: final carry-out.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; on acceptance, SHALL capture a, b and cin into registers, clear chunk index idx to 0, and enter RUN.
REQ-016 SHALL, on each RUN edge, add chunk idx of the captured operands with the carry register through one N-bit adder slice, write the result into sum[idx*N +: N], store the slice carry-out into the carry register, and increment idx.
REQ-017 SHALL leave RUN for DONE on the edge that processes idx = K-1, so out_valid rises exactly K edges after the accepting edge (K=1: one edge).
REQ-018 SHALL hold out_valid = 1 in DONE, with sum and cout (carry register) stable until consumed; on consumption SHALL return to IDLE.
REQ-019 SHALL ignore in_valid and all operand inputs outside IDLE; minimum issue interval is K+2 cycles.
REQ-020 SHALL size idx to max(1, $clog2(K)) bits, with no wrap beyond K-1.
REQ-021 SHALL produce sum/cout equal to {cout,sum} = a + b + cin computed at W+1 bits.
REQ-022 SHALL keep sum and cout at their last values while in IDLE; they are meaningful only while out_valid = 1.

Reset
REQ-023 SHALL, while rst_n = 0 (including mid-RUN or in DONE), force state IDLE, idx 0, carry 0, sum 0, cout 0, out_valid 0, busy 0, in_ready 1, and discard any in-flight operation.
REQ-024 SHALL accept a new request on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, when macro MULTIWORD_ADD_SUB_EN is defined, add input port sub (1 bit, captured with the operands); when sub = 1, SHALL use ~b as the b operand and force the initial carry to 1, ignoring cin, so cout = 1 means no borrow.
REQ-026 SHALL, when MULTIWORD_ADD_SUB_EN is undefined, have no sub port and always add.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, RUN, DONE) in shared package multiword_add_pkg.
REQ-028 SHALL implement the per-chunk adder as sub-module chunk_adder (N-bit, with carry-in and carry-out), instantiated exactly once.

Verification (N=4, K=4)
REQ-029 SHALL verify a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, with out_valid 4 edges after acceptance.
REQ-030 SHALL verify a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; and a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0.
REQ-031 SHALL verify that with out_ready held 0 for 5 cycles in DONE, sum, cout and out_valid stay constant and in_ready stays 0 despite in_valid=1; out_ready=1 -> IDLE, and in_ready=1 on the next cycle.
REQ-032 SHALL verify that rst_n pulsed low during RUN (idx=2) gives out_valid=0, in_ready=1 and sum=0 immediately, and that no result is emitted.
REQ-033 SHALL verify, with MULTIWORD_ADD_SUB_EN defined, sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; and a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
